// File: rtl/flag_accum_128.sv
// rtl/flag_accum_128.sv - accumulates byte-serial slice flags into 128-bit C/Z/S/O
module flag_accum_128 #(
   parameter int NSLICES = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       slice_valid,
   input  logic                       slice_c,
   input  logic                       slice_z,
   input  logic                       slice_s,
   input  logic                       slice_o,
   input  logic                       clr_err,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(NSLICES)-1:0] slice_cnt,
   output logic                       c_flag,
   output logic                       z_flag,
   output logic                       s_flag,
   output logic                       o_flag,
   output logic                       err
);

   localparam int CW = $clog2(NSLICES);
   localparam logic [CW-1:0] LAST_CNT = CW'(NSLICES - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

   state_t state, state_nxt;
   logic   zacc;
   logic   beat;
   logic   final_beat;
   logic   err_ev;

   // A start in ACCUM wins over a coincident beat, so that beat is never counted.
   assign beat       = (state == S_ACCUM) && slice_valid && !start;
   assign final_beat = beat && (slice_cnt == LAST_CNT);
   assign err_ev     = ((state == S_IDLE)  && slice_valid && !start) ||
                       ((state == S_ACCUM) && start) ||
                       ((state == S_DONE)  && slice_valid);

   assign busy = (state == S_ACCUM);
   assign done = (state == S_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_ACCUM;
         S_ACCUM: if (final_beat) state_nxt = S_DONE;
         S_DONE:  state_nxt = start ? S_ACCUM : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slice_cnt <= '0;
         zacc      <= 1'b1;
         c_flag    <= 1'b0;
         z_flag    <= 1'b0;
         s_flag    <= 1'b0;
         o_flag    <= 1'b0;
         err       <= 1'b0;
      end else begin
         err <= err_ev | (err & ~clr_err);
         if (start) begin
            slice_cnt <= '0;
            zacc      <= 1'b1;
         end else if (final_beat) begin
            slice_cnt <= '0;
            zacc      <= 1'b1;
            c_flag    <= slice_c;
            s_flag    <= slice_s;
            o_flag    <= slice_o;
            z_flag    <= zacc & slice_z;
         end else if (beat) begin
            slice_cnt <= slice_cnt + 1'b1;
            zacc      <= zacc & slice_z;
         end
      end
   end

endmodule

// File: tb/tb_flag_accum_128.sv
// tb/tb_flag_accum_128.sv - randomized self-checking bench for flag_accum_128
module tb_flag_accum_128;

   localparam int N  = 16;
   localparam int CW = $clog2(N);

   logic          clk = 1'b0;
   logic          rst, start, slice_valid, slice_c, slice_z, slice_s, slice_o, clr_err;
   logic          busy, done, c_flag, z_flag, s_flag, o_flag, err;
   logic [CW-1:0] slice_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: accepted beats of the current word kept as a queue of zero flags.
   bit m_busy, m_done, m_c, m_z, m_s, m_o, m_err;
   bit zq[$];

   flag_accum_128 #(.NSLICES(N)) dut (
      .clk(clk), .rst(rst), .start(start), .slice_valid(slice_valid),
      .slice_c(slice_c), .slice_z(slice_z), .slice_s(slice_s), .slice_o(slice_o),
      .clr_err(clr_err), .busy(busy), .done(done), .slice_cnt(slice_cnt),
      .c_flag(c_flag), .z_flag(z_flag), .s_flag(s_flag), .o_flag(o_flag), .err(err)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_busy = 0; m_done = 0; m_c = 0; m_z = 0; m_s = 0; m_o = 0; m_err = 0;
      zq.delete();
   endtask

   task automatic step(input bit st, input bit v, input bit c, input bit z,
                       input bit s, input bit o, input bit cl);
      bit ev, was_busy, was_done;
      start = st; slice_valid = v; slice_c = c; slice_z = z;
      slice_s = s; slice_o = o; clr_err = cl;
      @(posedge clk);
      was_busy = m_busy;
      was_done = m_done;
      ev = (!was_busy && !was_done && v && !st) || (was_busy && st) || (was_done && v);
      m_done = 0;
      if (was_busy) begin
         if (st) zq.delete();
         else if (v) begin
            zq.push_back(z);
            if (zq.size() == N) begin
               m_c = c; m_s = s; m_o = o; m_z = 1;
               foreach (zq[i]) m_z &= zq[i];
               zq.delete();
               m_busy = 0;
               m_done = 1;
            end
         end
      end else if (st) begin
         zq.delete();
         m_busy = 1;
      end
      if (ev) m_err = 1;
      else if (cl) m_err = 0;
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      rst = 1; start = 0; slice_valid = 0; slice_c = 0; slice_z = 0;
      slice_s = 0; slice_o = 0; clr_err = 0;
      #1;
      model_reset();
      n_checks++;
      if ({busy, done, err, c_flag, z_flag, s_flag, o_flag} !== 7'b0 || slice_cnt !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b err=%b cnt=%0d czso=%b%b%b%b, want all 0",
                  busy, done, err, slice_cnt, c_flag, z_flag, s_flag, o_flag);
      end
      @(posedge clk); #1;
      rst = 0;
      idle();
   endtask

   task automatic test_basic();
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < N; i++) begin
         n_checks++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy beat %0d: got busy=%b done=%b, want 1 0", i, busy, done);
         end
         step(0, 1, 0, 1, 0, 0, 0);
      end
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || {c_flag, z_flag, s_flag, o_flag} !== 4'b0100 ||
          err !== 1'b0 || slice_cnt !== '0) begin
         n_fail++;
         $display("FAIL basic_done: got done=%b busy=%b czso=%b%b%b%b err=%b cnt=%0d, want 1 0 0100 0 0",
                  done, busy, c_flag, z_flag, s_flag, o_flag, err, slice_cnt);
      end
      idle();
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_done_pulse: got done=%b, want 0", done);
      end
   endtask

   task automatic test_flags_hold();
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < N; i++) begin
         if (i == 15) step(0, 1, 1, 1, 1, 1, 0);
         else         step(0, 1, 0, (i == 5) ? 1'b0 : 1'b1, 0, 0, 0);
      end
      for (int k = 0; k <= 10; k++) begin
         n_checks++;
         if ({c_flag, z_flag, s_flag, o_flag} !== 4'b1011 || done !== (k == 0)) begin
            n_fail++;
            $display("FAIL flags_hold cycle %0d: got czso=%b%b%b%b done=%b, want 1011 done=%b",
                     k, c_flag, z_flag, s_flag, o_flag, done, k == 0);
         end
         if (k < 10) idle();
      end
   endtask

   task automatic test_gaps();
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < N; i++) begin
         n_checks++;
         if (slice_cnt !== CW'(i) || done !== 1'b0) begin
            n_fail++;
            $display("FAIL gaps_cnt beat %0d: got cnt=%0d done=%b, want %0d 0", i, slice_cnt, done, i);
         end
         step(0, 1, 0, 1, 0, 0, 0);
         if (i < N - 1) begin
            for (int g = 0; g < 3; g++) idle();
         end
      end
      n_checks++;
      if (done !== 1'b1 || z_flag !== 1'b1) begin
         n_fail++;
         $display("FAIL gaps_done: got done=%b z=%b, want 1 1", done, z_flag);
      end
      idle();
   endtask

   task automatic test_restart();
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) step(0, 1, 1, 0, 1, 1, 0);
      step(1, 1, 1, 0, 1, 1, 0);
      n_checks++;
      if (err !== 1'b1 || slice_cnt !== '0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_abort: got err=%b cnt=%0d busy=%b, want 1 0 1", err, slice_cnt, busy);
      end
      for (int i = 0; i < N; i++)
         step(0, 1, 1'($urandom), (i == 3) ? 1'b1 : 1'($urandom_range(0, 7) != 0),
              1'($urandom), 1'($urandom), 0);
      n_checks++;
      if (done !== 1'b1 || {c_flag, z_flag, s_flag, o_flag} !== {m_c, m_z, m_s, m_o}) begin
         n_fail++;
         $display("FAIL restart_flags: got done=%b czso=%b%b%b%b, want 1 %b%b%b%b",
                  done, c_flag, z_flag, s_flag, o_flag, m_c, m_z, m_s, m_o);
      end
      step(0, 0, 0, 0, 0, 0, 1);
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_clr_err: got err=%b, want 0", err);
      end
   endtask

   task automatic test_idle_valid_back_to_back();
      bit [3:0] saved;
      saved = {c_flag, z_flag, s_flag, o_flag};
      step(0, 1, 1, 0, 1, 1, 0);
      n_checks++;
      if (err !== 1'b1 || slice_cnt !== '0 || busy !== 1'b0 ||
          {c_flag, z_flag, s_flag, o_flag} !== saved) begin
         n_fail++;
         $display("FAIL idle_valid: got err=%b cnt=%0d busy=%b czso=%b%b%b%b, want 1 0 0 %b",
                  err, slice_cnt, busy, c_flag, z_flag, s_flag, o_flag, saved);
      end
      step(1, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < N; i++) step(0, 1, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0 || slice_cnt !== '0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL back_to_back: got busy=%b done=%b cnt=%0d err=%b, want 1 0 0 0",
                  busy, done, slice_cnt, err);
      end
      for (int i = 0; i < N; i++) step(0, 1, 1, 1, 0, 1, 0);
      n_checks++;
      if (done !== 1'b1 || {c_flag, z_flag, s_flag, o_flag} !== 4'b1101) begin
         n_fail++;
         $display("FAIL back_to_back_flags: got done=%b czso=%b%b%b%b, want 1 1101",
                  done, c_flag, z_flag, s_flag, o_flag);
      end
      idle();
   endtask

   task automatic test_rst_mid();
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) step(0, 1, 1, 1, 1, 1, 0);
      rst = 1;
      #1;
      model_reset();
      n_checks++;
      if ({busy, done, err, c_flag, z_flag, s_flag, o_flag} !== 7'b0 || slice_cnt !== '0) begin
         n_fail++;
         $display("FAIL rst_mid: got busy=%b done=%b err=%b cnt=%0d czso=%b%b%b%b, want all 0",
                  busy, done, err, slice_cnt, c_flag, z_flag, s_flag, o_flag);
      end
      @(negedge clk);
      rst = 0;
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < N; i++) step(0, 1, 1, 1, 0, 0, 0);
      n_checks++;
      if (done !== 1'b1 || {c_flag, z_flag, s_flag, o_flag} !== 4'b1100) begin
         n_fail++;
         $display("FAIL rst_mid_recover: got done=%b czso=%b%b%b%b, want 1 1100",
                  done, c_flag, z_flag, s_flag, o_flag);
      end
      idle();
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
              $urandom_range(0, 15) != 0, 1'($urandom), 1'($urandom),
              $urandom_range(0, 9) == 0);
         n_checks++;
         if (busy !== m_busy || done !== m_done || err !== m_err ||
             32'(slice_cnt) !== zq.size() ||
             {c_flag, z_flag, s_flag, o_flag} !== {m_c, m_z, m_s, m_o}) begin
            n_fail++;
            $display("FAIL random cycle %0d: got busy=%b done=%b err=%b cnt=%0d czso=%b%b%b%b, want %b %b %b %0d %b%b%b%b",
                     cyc, busy, done, err, slice_cnt, c_flag, z_flag, s_flag, o_flag,
                     m_busy, m_done, m_err, zq.size(), m_c, m_z, m_s, m_o);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_flags_hold();
      test_gaps();
      test_restart();
      test_idle_valid_back_to_back();
      test_rst_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
